multicycle_sequencer: RTL and testbench

- Parametrised multicycle control sequencer for the CPU core. It steps a state counter from 0 to NUM_STATES-1 once per instruction.
- Stalls on memory waitRequest, but only in states marked as memory-access states.
- Supports early instruction completion, halting at an instruction boundary, and recovery from illegal states.
- Provides binary and one-hot state encodings plus a retired-instruction counter for the decode and datapath control logic.

---
 rtl/multicycle_sequencer.sv | 98 +++++++++
 tb/tb_multicycle_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: walks state 0..NUM_STATES-1 once per instruction,
// with memory stalls, early completion, boundary halting and illegal-state recovery.
module multicycle_sequencer #(
  parameter int unsigned           NUM_STATES = 5,
  parameter int unsigned           STATE_W    = 3,
  parameter logic [NUM_STATES-1:0] STALL_MASK = 5'b11111,
  parameter int unsigned           COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  waitRequest,
  input  logic                  early_done,
  input  logic                  halt,
  output logic [STATE_W-1:0]    state,
  output logic [NUM_STATES-1:0] state_onehot,
  output logic                  instr_done,
  output logic                  stalled,
  output logic                  halted,
  output logic [COUNT_W-1:0]    instr_count
);

  typedef enum logic {
    RUN  = 1'b0,
    PARK = 1'b1
  } mode_e;

  localparam logic [STATE_W:0]   NUM_S  = (STATE_W + 1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] LAST_S = STATE_W'(NUM_STATES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  mode_e              mode_q, mode_d;

  logic legal;
  logic mask_bit;
  logic stall_en;
  logic last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      count_q <= '0;
      mode_q  <= RUN;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  // Mask lookup and one-hot decode are done by comparison so that an
  // out-of-range state never indexes past the end of STALL_MASK.
  always_comb begin
    legal        = ({1'b0, state_q} < NUM_S);
    mask_bit     = 1'b0;
    state_onehot = '0;
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      if (state_q == STATE_W'(i)) begin
        mask_bit        = STALL_MASK[i];
        state_onehot[i] = legal;
      end
    end
    stall_en = legal && mask_bit && waitRequest;
    last     = (state_q == LAST_S) || early_done;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mode_d     = mode_q;
    instr_done = 1'b0;
    stalled    = 1'b0;
    if (!legal) begin
      state_d = '0;
    end else if (mode_q == PARK) begin
      state_d = '0;
      if (!halt) begin
        mode_d = RUN;
      end
    end else if (stall_en) begin
      stalled = 1'b1;
    end else if (last) begin
      state_d    = '0;
      instr_done = 1'b1;
      count_d    = count_q + COUNT_W'(1);
      if (halt) begin
        mode_d = PARK;
      end
    end else begin
      state_d = state_q + STATE_W'(1);
    end
  end

  assign state       = state_q;
  assign halted      = (mode_q == PARK);
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed scoreboard bench for multicycle_sequencer: default-sized instance with a
// partial stall mask, plus a 6-state / 4-bit-counter instance for wrap and illegal-state recovery.
module tb_multicycle_sequencer;

  logic clk;
  logic rst0_n, w0, e0, h0;
  logic rst1_n, w1, e1, h1;

  logic [2:0]  st0;
  logic [4:0]  oh0;
  logic        done0, stl0, hlt0;
  logic [15:0] cnt0;

  logic [2:0]  st1;
  logic [5:0]  oh1;
  logic        done1, stl1, hlt1;
  logic [3:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  st;
    logic [5:0]  oh;
    logic        done;
    logic        stall;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  multicycle_sequencer #(
    .NUM_STATES(5),
    .STATE_W   (3),
    .STALL_MASK(5'b01001),
    .COUNT_W   (16)
  ) u0 (
    .clk         (clk),
    .reset       (rst0_n),
    .waitRequest (w0),
    .early_done  (e0),
    .halt        (h0),
    .state       (st0),
    .state_onehot(oh0),
    .instr_done  (done0),
    .stalled     (stl0),
    .halted      (hlt0),
    .instr_count (cnt0)
  );

  multicycle_sequencer #(
    .NUM_STATES(6),
    .STATE_W   (3),
    .STALL_MASK(6'h3F),
    .COUNT_W   (4)
  ) u1 (
    .clk         (clk),
    .reset       (rst1_n),
    .waitRequest (w1),
    .early_done  (e1),
    .halt        (h1),
    .state       (st1),
    .state_onehot(oh1),
    .instr_done  (done1),
    .stalled     (stl1),
    .halted      (hlt1),
    .instr_count (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, record expectations for this cycle,
  // compare once the combinational outputs settle, then move to the next falling edge.
  task automatic cyc0(input logic w, input logic e, input logic h,
                      input int es, input logic ed, input logic est,
                      input logic eh, input int ec);
    exp_t x;
    w0 = w; e0 = e; h0 = h;
    x.st = 3'(es); x.oh = 6'(5'b00001 << es); x.done = ed;
    x.stall = est; x.halted = eh; x.cnt = 16'(ec);
    q.push_back(x);
    #2;
    x = q.pop_front();
    check("u0.state",        32'(st0),   32'(x.st));
    check("u0.state_onehot", 32'(oh0),   32'(x.oh));
    check("u0.instr_done",   32'(done0), 32'(x.done));
    check("u0.stalled",      32'(stl0),  32'(x.stall));
    check("u0.halted",       32'(hlt0),  32'(x.halted));
    check("u0.instr_count",  32'(cnt0),  32'(x.cnt));
    @(negedge clk);
  endtask

  task automatic cyc1(input int es, input logic ed, input int ec);
    exp_t x;
    x.st = 3'(es); x.oh = 6'(6'b000001 << es); x.done = ed;
    x.stall = 1'b0; x.halted = 1'b0; x.cnt = 16'(ec);
    q.push_back(x);
    #2;
    x = q.pop_front();
    check("u1.state",        32'(st1),   32'(x.st));
    check("u1.state_onehot", 32'(oh1),   32'(x.oh));
    check("u1.instr_done",   32'(done1), 32'(x.done));
    check("u1.stalled",      32'(stl1),  32'(x.stall));
    check("u1.instr_count",  32'(cnt1),  32'(x.cnt));
    @(negedge clk);
  endtask

  initial begin
    rst0_n = 1'b0; w0 = 1'b0; e0 = 1'b0; h0 = 1'b0;
    rst1_n = 1'b0; w1 = 1'b0; e1 = 1'b0; h1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.state",  32'(st0),  32'd0);
    check("reset.count",  32'(cnt0), 32'd0);
    check("reset.halted", 32'(hlt0), 32'd0);
    check("reset.onehot", 32'(oh0),  32'd1);
    rst0_n = 1'b1;

    // free run: 0,1,2,3,4,0,1,2,3,4,0,1
    for (int i = 0; i < 12; i++)
      cyc0(1'b0, 1'b0, 1'b0, i % 5, (i % 5) == 4, 1'b0, 1'b0, i / 5);

    // stall in state 3 (masked), three extra cycles
    cyc0(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++)
      cyc0(1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 2);
    cyc0(1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 2);
    cyc0(1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 2);
    // waitRequest in unmasked state 2 does nothing
    cyc0(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3);
    cyc0(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 3);
    cyc0(1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 3);
    cyc0(1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 3);
    cyc0(1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 3);

    // early_done in state 2
    cyc0(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 4);
    cyc0(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 4);
    cyc0(1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 4);
    // early_done ignored while stalled
    cyc0(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5);
    cyc0(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 5);
    cyc0(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 5);
    cyc0(1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0, 5);
    cyc0(1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 5);
    cyc0(1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 5);
    // single-state instruction, then a stall in masked state 0
    cyc0(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 6);
    cyc0(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 7);

    // halt raised in state 1: instruction completes, then parks
    cyc0(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 7);
    cyc0(1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 7);
    cyc0(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 7);
    cyc0(1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 7);
    cyc0(1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 7);
    for (int i = 0; i < 3; i++)
      cyc0(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8);
    cyc0(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8);
    cyc0(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8);
    cyc0(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8);
    cyc0(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8);
    cyc0(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8);

    // asynchronous reset in the middle of state 3
    w0 = 1'b0; e0 = 1'b0; h0 = 1'b0;
    #1;
    check("pre_reset.state", 32'(st0),  32'd3);
    check("pre_reset.count", 32'(cnt0), 32'd8);
    #1;
    rst0_n = 1'b0;
    #1;
    check("async_reset.state",  32'(st0),   32'd0);
    check("async_reset.count",  32'(cnt0),  32'd0);
    check("async_reset.halted", 32'(hlt0),  32'd0);
    check("async_reset.done",   32'(done0), 32'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    cyc0(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    cyc0(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0);

    // 6-state instance: 16 instructions wrap the 4-bit counter
    rst1_n = 1'b1;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 6; j++)
        cyc1(j, j == 5, i);
    cyc1(0, 1'b0, 0);

    // illegal state 7 recovers to 0 with no count change
    force u1.state_q = 3'd7;
    #2;
    check("illegal.state",  32'(st1),   32'd7);
    check("illegal.onehot", 32'(oh1),   32'd0);
    check("illegal.done",   32'(done1), 32'd0);
    check("illegal.count",  32'(cnt1),  32'd0);
    #1;
    release u1.state_q;
    @(negedge clk);
    check("recover.state",  32'(st1),  32'd0);
    check("recover.onehot", 32'(oh1),  32'd1);
    check("recover.count",  32'(cnt1), 32'd0);
    @(negedge clk);
    check("recover.next",   32'(st1),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
